// File: rtl/maze_pkg.sv
// maze_pkg: shared types and constants for the maze sprite controller.
//   - game_state_e : game state encoding (RUN=0, HIT=1, WIN=2, OVER=3)
//   - colour constants (12-bit RGB)
//   - COORD_W / coord_t : scan and sprite coordinate width
//   - step_axis() : one-axis move with bounds handling
// Optional feature macro: WRAP_EN (wrap-around at the play-field bounds
// instead of saturating).
package maze_pkg;

    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HIT  = 2'd1,
        WIN  = 2'd2,
        OVER = 2'd3
    } game_state_e;

    localparam logic [11:0] BLACK  = 12'h000;
    localparam logic [11:0] WHITE  = 12'hFFF;
    localparam logic [11:0] RED    = 12'hF00;
    localparam logic [11:0] GREEN  = 12'h0F0;
    localparam logic [11:0] YELLOW = 12'hFF0;
    localparam logic [11:0] CYAN   = 12'h0FF;
    localparam logic [11:0] BLUE   = 12'h00F;

    // Move one axis by step toward inc or dec; opposing presses cancel.
    // Arithmetic is done at 32 bits so neither bound check can wrap.
    function automatic coord_t step_axis(
        input coord_t      pos,
        input logic        inc,
        input logic        dec,
        input int unsigned lo,
        input int unsigned hi,
        input int unsigned step
    );
        int unsigned p;
        int unsigned r;
        p = 32'(pos);
        r = p;
        if (inc && !dec) begin
            if (p + step > hi) begin
`ifdef WRAP_EN
                r = lo;
`else
                r = hi;
`endif
            end else begin
                r = p + step;
            end
        end else if (dec && !inc) begin
            if (p < lo + step) begin
`ifdef WRAP_EN
                r = hi;
`else
                r = lo;
`endif
            end else begin
                r = p - step;
            end
        end
        return coord_t'(r);
    endfunction

endpackage

// File: rtl/maze_sprite_controller_if.sv
// maze_sprite_controller_if: bundles the scan inputs (bright, hCount,
// vCount, wall_fill, goal_fill), the debounced buttons and the display
// outputs (rgb, background, xpos, ypos, lives, state) of the controller.
//   master : the environment (display controller, renderer, buttons)
//   slave  : the sprite controller
interface maze_sprite_controller_if;
    import maze_pkg::*;

    logic        bright;
    logic        up;
    logic        down;
    logic        left;
    logic        right;
    coord_t      hCount;
    coord_t      vCount;
    logic        wall_fill;
    logic        goal_fill;
    logic [11:0] rgb;
    logic [11:0] background;
    coord_t      xpos;
    coord_t      ypos;
    logic [2:0]  lives;
    logic [1:0]  state;

    modport master (
        output bright, up, down, left, right, hCount, vCount, wall_fill, goal_fill,
        input  rgb, background, xpos, ypos, lives, state
    );

    modport slave (
        input  bright, up, down, left, right, hCount, vCount, wall_fill, goal_fill,
        output rgb, background, xpos, ypos, lives, state
    );

endinterface

// File: rtl/maze_sprite_controller_scan_flag_latch.sv
// scan_flag_latch: frame_end strobe plus sticky per-frame collision flags.
//   clk, rst        : pixel clock, async active-high reset
//   hCount_i/vCount_i : scan position; (0,0) marks frame_end
//   bright_i, sprite_fill_i, wall_fill_i, goal_fill_i : current pixel
//   frame_end_o     : high for the (0,0) pixel
//   hit_o / goal_o  : flags accumulated over the previous frame, only
//                     valid (non-zero) on the frame_end cycle
module scan_flag_latch
    import maze_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  coord_t hCount_i,
    input  coord_t vCount_i,
    input  logic   bright_i,
    input  logic   sprite_fill_i,
    input  logic   wall_fill_i,
    input  logic   goal_fill_i,
    output logic   frame_end_o,
    output logic   hit_o,
    output logic   goal_o
);

    logic hit_q, hit_d;
    logic goal_q, goal_d;

    assign frame_end_o = (hCount_i == '0) && (vCount_i == '0);

    // The frame_end pixel itself starts the new frame with cleared flags.
    always_comb begin
        hit_d  = hit_q  | (bright_i & sprite_fill_i & wall_fill_i);
        goal_d = goal_q | (bright_i & sprite_fill_i & goal_fill_i);
        if (frame_end_o) begin
            hit_d  = 1'b0;
            goal_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= 1'b0;
            goal_q <= 1'b0;
        end else begin
            hit_q  <= hit_d;
            goal_q <= goal_d;
        end
    end

    assign hit_o  = frame_end_o & hit_q;
    assign goal_o = frame_end_o & goal_q;

endmodule

// File: rtl/maze_sprite_controller.sv
// maze_sprite_controller: moves a square sprite on button input once every
// MOVE_DIV frames, detects wall/goal collisions during the scan and runs
// the RUN/HIT/WIN/OVER game state machine with a lives counter.
//   clk, rst : pixel clock, async active-high reset
//   bus      : maze_sprite_controller_if.slave (scan inputs, buttons,
//              rgb/background/xpos/ypos/lives/state outputs)
// Optional feature macro: WRAP_EN (sprite wraps at the bounds).
module maze_sprite_controller
    import maze_pkg::*;
#(
    parameter int unsigned HALF         = 5,
    parameter int unsigned STEP         = 1,
    parameter int unsigned MOVE_DIV     = 1,
    parameter int unsigned X_MIN        = 150,
    parameter int unsigned X_MAX        = 780,
    parameter int unsigned Y_MIN        = 40,
    parameter int unsigned Y_MAX        = 510,
    parameter int unsigned X_START      = 450,
    parameter int unsigned Y_START      = 250,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned HIT_FRAMES   = 60,
    parameter logic [11:0] SPRITE_COLOR = 12'hF00
) (
    input logic               clk,
    input logic               rst,
    maze_sprite_controller_if.slave bus
);

    localparam int unsigned MCW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    // hit_cnt needs bit 3 for the flash even for short HIT periods
    localparam int unsigned HCW = ($clog2(HIT_FRAMES) < 4) ? 4 : $clog2(HIT_FRAMES);

    game_state_e    state_q, state_d;
    coord_t         xpos_q, xpos_d;
    coord_t         ypos_q, ypos_d;
    logic [2:0]     lives_q, lives_d;
    logic [HCW-1:0] hit_cnt_q, hit_cnt_d;
    logic [MCW-1:0] move_cnt_q, move_cnt_d;
    logic [11:0]    bg_q, bg_d;

    logic        frame_end;
    logic        hit_s;
    logic        goal_s;
    logic        sprite_fill;
    logic        blank;
    logic [11:0] rgb;

    // 11-bit compare with HALF moved to the other side avoids underflow.
    logic [10:0] h_w, v_w, x_w, y_w;
    assign h_w = {1'b0, bus.hCount};
    assign v_w = {1'b0, bus.vCount};
    assign x_w = {1'b0, xpos_q};
    assign y_w = {1'b0, ypos_q};

    assign sprite_fill = (h_w + 11'(HALF) >= x_w) && (h_w <= x_w + 11'(HALF)) &&
                         (v_w + 11'(HALF) >= y_w) && (v_w <= y_w + 11'(HALF));

    scan_flag_latch u_flags (
        .clk           (clk),
        .rst           (rst),
        .hCount_i      (bus.hCount),
        .vCount_i      (bus.vCount),
        .bright_i      (bus.bright),
        .sprite_fill_i (sprite_fill),
        .wall_fill_i   (bus.wall_fill),
        .goal_fill_i   (bus.goal_fill),
        .frame_end_o   (frame_end),
        .hit_o         (hit_s),
        .goal_o        (goal_s)
    );

    always_comb begin
        state_d    = state_q;
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;
        lives_d    = lives_q;
        hit_cnt_d  = hit_cnt_q;
        move_cnt_d = move_cnt_q;
        bg_d       = bg_q;

        if (frame_end) begin
            case (state_q)
                RUN: begin
                    if (hit_s) begin
                        lives_d   = lives_q - 3'd1;
                        xpos_d    = coord_t'(X_START);
                        ypos_d    = coord_t'(Y_START);
                        hit_cnt_d = '0;
                        state_d   = (lives_q == 3'd1) ? OVER : HIT;
                    end else if (goal_s) begin
                        state_d = WIN;
                    end else if (move_cnt_q == MCW'(MOVE_DIV - 1)) begin
                        xpos_d     = step_axis(xpos_q, bus.right, bus.left, X_MIN, X_MAX, STEP);
                        ypos_d     = step_axis(ypos_q, bus.down, bus.up, Y_MIN, Y_MAX, STEP);
                        move_cnt_d = '0;
                    end else begin
                        move_cnt_d = move_cnt_q + MCW'(1);
                    end
                end
                HIT: begin
                    hit_cnt_d = hit_cnt_q + HCW'(1);
                    if (hit_cnt_q == HCW'(HIT_FRAMES - 1)) begin
                        state_d    = RUN;
                        move_cnt_d = '0;
                    end
                end
                default: ;
            endcase

            // Background follows the state being entered; in RUN/HIT it
            // remembers the highest-priority button held at frame_end.
            case (state_d)
                WIN:  bg_d = GREEN;
                OVER: bg_d = RED;
                default: begin
                    if (bus.right)     bg_d = YELLOW;
                    else if (bus.left) bg_d = CYAN;
                    else if (bus.down) bg_d = GREEN;
                    else if (bus.up)   bg_d = BLUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            xpos_q     <= coord_t'(X_START);
            ypos_q     <= coord_t'(Y_START);
            lives_q    <= 3'(LIVES);
            hit_cnt_q  <= '0;
            move_cnt_q <= '0;
            bg_q       <= WHITE;
        end else begin
            state_q    <= state_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            lives_q    <= lives_d;
            hit_cnt_q  <= hit_cnt_d;
            move_cnt_q <= move_cnt_d;
            bg_q       <= bg_d;
        end
    end

    // Sprite flashes off while recovering from a hit.
    assign blank = (state_q == HIT) && hit_cnt_q[3];

    always_comb begin
        rgb = bg_q;
        if (!bus.bright)                rgb = BLACK;
        else if (sprite_fill && !blank) rgb = SPRITE_COLOR;
        else if (bus.wall_fill)         rgb = BLACK;
    end

    assign bus.rgb        = rgb;
    assign bus.background = bg_q;
    assign bus.xpos       = xpos_q;
    assign bus.ypos       = ypos_q;
    assign bus.lives      = lives_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_maze_sprite_controller.sv
module tb_maze_sprite_controller;

    localparam int HALF       = 5;
    localparam int STEP       = 1;
    localparam int X_MIN      = 150;
    localparam int X_MAX      = 780;
    localparam int Y_MIN      = 40;
    localparam int Y_MAX      = 510;
    localparam int X_START    = 450;
    localparam int Y_START    = 250;
    localparam int LIVES      = 3;
    localparam int HIT_FRAMES = 60;
    localparam logic [11:0] C_SPRITE = 12'hF00;

    localparam int M_RUN  = 0;
    localparam int M_HIT  = 1;
    localparam int M_WIN  = 2;
    localparam int M_OVER = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maze_sprite_controller_if bus0 ();
    maze_sprite_controller_if bus4 ();

    assign bus4.bright    = bus0.bright;
    assign bus4.up        = bus0.up;
    assign bus4.down      = bus0.down;
    assign bus4.left      = bus0.left;
    assign bus4.right     = bus0.right;
    assign bus4.hCount    = bus0.hCount;
    assign bus4.vCount    = bus0.vCount;
    assign bus4.wall_fill = bus0.wall_fill;
    assign bus4.goal_fill = bus0.goal_fill;

    maze_sprite_controller #(.MOVE_DIV(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    maze_sprite_controller #(.MOVE_DIV(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // Reference model, one slot per DUT (index 0: MOVE_DIV=1, 1: MOVE_DIV=4)
    int          mdiv [2] = '{1, 4};
    int          mx   [2];
    int          my   [2];
    int          ml   [2];
    int          mst  [2];
    int          mhc  [2];
    int          mframes [2];
    logic [11:0] mbg  [2];
    bit          mhit [2];
    bit          mgoal[2];

    int ncmp  = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int limit(input int v, input int lo, input int hi);
`ifdef WRAP_EN
        if (v > hi) return lo;
        if (v < lo) return hi;
`else
        if (v > hi) return hi;
        if (v < lo) return lo;
`endif
        return v;
    endfunction

    function automatic bit inside_spr(input int k, input int h, input int v);
        return (h >= mx[k] - HALF) && (h <= mx[k] + HALF) &&
               (v >= my[k] - HALF) && (v <= my[k] + HALF);
    endfunction

    function automatic logic [11:0] exp_rgb(input int k, input int h, input int v, input bit b, input bit w);
        if (!b) return 12'h000;
        if (inside_spr(k, h, v) && !(mst[k] == M_HIT && (mhc[k] & 8) != 0)) return C_SPRITE;
        if (w) return 12'h000;
        return mbg[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k] = X_START; my[k] = Y_START; ml[k] = LIVES; mst[k] = M_RUN;
            mhc[k] = 0; mframes[k] = 0; mbg[k] = 12'hFFF; mhit[k] = 0; mgoal[k] = 0;
        end
    endtask

    // btn = {up, down, left, right}
    task automatic model_frame_end(input logic [3:0] btn);
        int dx;
        int dy;
        for (int k = 0; k < 2; k++) begin
            if (mst[k] == M_RUN) begin
                if (mhit[k]) begin
                    ml[k]--;
                    mx[k] = X_START; my[k] = Y_START; mhc[k] = 0;
                    mst[k] = (ml[k] == 0) ? M_OVER : M_HIT;
                end else if (mgoal[k]) begin
                    mst[k] = M_WIN;
                end else begin
                    mframes[k]++;
                    if (mframes[k] == mdiv[k]) begin
                        mframes[k] = 0;
                        dx = (btn[0] ? STEP : 0) - (btn[1] ? STEP : 0);
                        dy = (btn[2] ? STEP : 0) - (btn[3] ? STEP : 0);
                        if (dx != 0) mx[k] = limit(mx[k] + dx, X_MIN, X_MAX);
                        if (dy != 0) my[k] = limit(my[k] + dy, Y_MIN, Y_MAX);
                    end
                end
            end else if (mst[k] == M_HIT) begin
                mhc[k]++;
                if (mhc[k] == HIT_FRAMES) begin
                    mst[k] = M_RUN;
                    mframes[k] = 0;
                end
            end
            if (mst[k] == M_WIN)       mbg[k] = 12'h0F0;
            else if (mst[k] == M_OVER) mbg[k] = 12'hF00;
            else if (btn[0])           mbg[k] = 12'hFF0;
            else if (btn[1])           mbg[k] = 12'h0FF;
            else if (btn[2])           mbg[k] = 12'h0F0;
            else if (btn[3])           mbg[k] = 12'h00F;
            mhit[k] = 0;
            mgoal[k] = 0;
        end
    endtask

    task automatic check_regs();
        check("xpos0",  32'(bus0.xpos), 32'(mx[0]));
        check("ypos0",  32'(bus0.ypos), 32'(my[0]));
        check("lives0", 32'(bus0.lives), 32'(ml[0]));
        check("state0", 32'(bus0.state), 32'(mst[0]));
        check("bg0",    32'(bus0.background), 32'(mbg[0]));
        check("xpos4",  32'(bus4.xpos), 32'(mx[1]));
        check("ypos4",  32'(bus4.ypos), 32'(my[1]));
        check("lives4", 32'(bus4.lives), 32'(ml[1]));
        check("state4", 32'(bus4.state), 32'(mst[1]));
        check("bg4",    32'(bus4.background), 32'(mbg[1]));
    endtask

    task automatic set_idle();
        bus0.hCount = 10'd1; bus0.vCount = 10'd1;
        bus0.bright = 1'b0; bus0.wall_fill = 1'b0; bus0.goal_fill = 1'b0;
        {bus0.up, bus0.down, bus0.left, bus0.right} = 4'b0000;
    endtask

    task automatic drive_pixel(input int h, input int v, input bit b, input bit w, input bit g);
        @(negedge clk);
        bus0.hCount = 10'(h); bus0.vCount = 10'(v);
        bus0.bright = b; bus0.wall_fill = w; bus0.goal_fill = g;
        #1;
        check("rgb0", 32'(bus0.rgb), 32'(exp_rgb(0, h, v, b, w)));
        check("rgb4", 32'(bus4.rgb), 32'(exp_rgb(1, h, v, b, w)));
        for (int k = 0; k < 2; k++) begin
            if (b && inside_spr(k, h, v)) begin
                mhit[k]  = mhit[k]  | w;
                mgoal[k] = mgoal[k] | g;
            end
        end
    endtask

    task automatic frame_edge(input logic [3:0] btn);
        @(negedge clk);
        bus0.hCount = 10'd0; bus0.vCount = 10'd0;
        bus0.bright = 1'b0; bus0.wall_fill = 1'b0; bus0.goal_fill = 1'b0;
        {bus0.up, bus0.down, bus0.left, bus0.right} = btn;
        #1;
        check("rgb_fe", 32'(bus0.rgb), 32'd0);
        @(posedge clk);
        #1;
        model_frame_end(btn);
        check_regs();
    endtask

    // One frame: frame_end, a forced pixel at sprite 0's centre carrying the
    // requested wall/goal, then random pixels that never touch a sprite with
    // a bright wall/goal.
    task automatic run_frame(input bit hit, input bit goal, input logic [3:0] btn);
        int h;
        int v;
        bit b;
        bit w;
        bit g;
        frame_edge(btn);
        drive_pixel(mx[0], my[0], 1'b1, hit, goal);
        for (int i = 0; i < 7; i++) begin
            h = mx[0] - 8 + int'($urandom_range(16, 0));
            v = my[0] - 8 + int'($urandom_range(16, 0));
            b = ($urandom_range(3, 0) != 0);
            w = 1'($urandom_range(1, 0));
            g = 1'($urandom_range(1, 0));
            if (b && (inside_spr(0, h, v) || inside_spr(1, h, v))) begin
                w = 1'b0;
                g = 1'b0;
            end
            drive_pixel(h, v, b, w, g);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        #1;
        model_reset();
        check_regs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        set_idle();
        do_reset();

        // 1: hold right for 10 frames
        for (int i = 0; i < 10; i++) run_frame(1'b0, 1'b0, 4'b0001);
        check("t1_x", 32'(bus0.xpos), 32'd460);
        check("t1_y", 32'(bus0.ypos), 32'd250);
        check("t1_bg", 32'(bus0.background), 32'hFF0);

        // 2: walk left to 152, then 5 more frames against the left bound
        for (int i = 0; i < 308; i++) run_frame(1'b0, 1'b0, 4'b0010);
        check("t2_x152", 32'(bus0.xpos), 32'd152);
        for (int i = 0; i < 5; i++) run_frame(1'b0, 1'b0, 4'b0010);
`ifdef WRAP_EN
        check("t2_xend", 32'(bus0.xpos), 32'd778);
`else
        check("t2_xend", 32'(bus0.xpos), 32'd150);
`endif
        check("t2_bg", 32'(bus0.background), 32'h0FF);

        // 3: one collision, HIT for 60 frames with buttons ignored
        run_frame(1'b1, 1'b0, 4'b0000);
        run_frame(1'b0, 1'b0, 4'b0001);
        check("t3_state", 32'(bus0.state), 32'd1);
        check("t3_lives", 32'(bus0.lives), 32'd2);
        check("t3_x", 32'(bus0.xpos), 32'd450);
        check("t3_y", 32'(bus0.ypos), 32'd250);
        for (int i = 0; i < 59; i++) run_frame(i == 20, 1'b0, 4'b0001);
        check("t3_still_hit", 32'(bus0.state), 32'd1);
        check("t3_frozen_x", 32'(bus0.xpos), 32'd450);
        run_frame(1'b0, 1'b0, 4'b0001);
        check("t3_run", 32'(bus0.state), 32'd0);
        check("t3_run_x", 32'(bus0.xpos), 32'd450);
        run_frame(1'b0, 1'b0, 4'b0001);
        check("t3_move", 32'(bus0.xpos), 32'd451);

        // 4: two more collisions -> OVER, then frozen
        run_frame(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 61; i++) run_frame(1'b0, 1'b0, 4'b0100);
        check("t4_lives1", 32'(bus0.lives), 32'd1);
        check("t4_run", 32'(bus0.state), 32'd0);
        run_frame(1'b1, 1'b0, 4'b0000);
        run_frame(1'b0, 1'b0, 4'b0001);
        check("t4_over", 32'(bus0.state), 32'd3);
        check("t4_lives0", 32'(bus0.lives), 32'd0);
        check("t4_bg", 32'(bus0.background), 32'hF00);
        for (int i = 0; i < 5; i++) run_frame(1'b1, 1'b1, 4'b1111);
        check("t4_frozen_state", 32'(bus0.state), 32'd3);
        check("t4_frozen_x", 32'(bus0.xpos), 32'd450);

        // 5: wall and goal together -> HIT; goal alone -> WIN
        do_reset();
        run_frame(1'b1, 1'b1, 4'b0000);
        run_frame(1'b0, 1'b0, 4'b0000);
        check("t5_hit", 32'(bus0.state), 32'd1);
        check("t5_lives", 32'(bus0.lives), 32'd2);
        for (int i = 0; i < 60; i++) run_frame(1'b0, 1'b0, 4'b1000);
        check("t5_run", 32'(bus0.state), 32'd0);
        run_frame(1'b0, 1'b1, 4'b0000);
        run_frame(1'b0, 1'b0, 4'b0001);
        check("t5_win", 32'(bus0.state), 32'd2);
        check("t5_bg", 32'(bus0.background), 32'h0F0);
        for (int i = 0; i < 3; i++) run_frame(1'b1, 1'b0, 4'b0001);
        check("t5_frozen", 32'(bus0.state), 32'd2);

        // 6: opposing buttons cancel; up alone with MOVE_DIV=4
        do_reset();
        for (int i = 0; i < 8; i++) run_frame(1'b0, 1'b0, 4'b0011);
        check("t6_x0", 32'(bus0.xpos), 32'd450);
        check("t6_x4", 32'(bus4.xpos), 32'd450);
        for (int i = 0; i < 8; i++) run_frame(1'b0, 1'b0, 4'b1000);
        check("t6_y4", 32'(bus4.ypos), 32'd248);
        check("t6_y0", 32'(bus0.ypos), 32'd242);

        // mid-frame reset discards a pending collision
        run_frame(1'b0, 1'b0, 4'b0001);
        drive_pixel(mx[0], my[0], 1'b1, 1'b1, 1'b0);
        do_reset();
        check("t6_rst_x", 32'(bus0.xpos), 32'd450);
        check("t6_rst_bg", 32'(bus0.background), 32'hFFF);
        run_frame(1'b0, 1'b0, 4'b0000);
        run_frame(1'b0, 1'b0, 4'b0000);
        check("t6_no_hit", 32'(bus0.state), 32'd0);
        check("t6_lives", 32'(bus0.lives), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/maze_sprite_controller.md
Name: maze_sprite_controller

Overview:
Next-generation player controller for the VGA maze game. It moves a parametrised square sprite on button input, once every MOVE_DIV frames. It detects per-pixel collisions with the maze walls and the goal region during the scan, and runs a RUN/HIT/WIN/OVER game state machine with a lives counter. It sits between the button debouncers, the display_controller (hCount/vCount/bright) and the maze renderer (wall_fill/goal_fill), and drives final rgb.

Parameters:
HALF, 5, sprite half-size in pixels; sprite spans pos-HALF..pos+HALF
STEP, 1, pixels moved per move event
MOVE_DIV, 1, frames between move events (1 = every frame)
X_MIN, 150, minimum sprite centre x
X_MAX, 780, maximum sprite centre x
Y_MIN, 40, minimum sprite centre y
Y_MAX, 510, maximum sprite centre y
X_START, 450, reset/respawn centre x
Y_START, 250, reset/respawn centre y
LIVES, 3, initial life count (1..7)
HIT_FRAMES, 60, frames frozen after a collision
SPRITE_COLOR, 12'hF00, sprite colour

Ports:
clk  in  1  pixel-rate clock
rst  in  1  asynchronous, active-high reset
bright  in  1  high inside visible area
up, down, left, right  in  1 each  debounced buttons, level
hCount, vCount  in  10 each  scan counters from display_controller
wall_fill  in  1  current pixel is maze wall
goal_fill  in  1  current pixel is goal region
rgb  out  12  pixel colour
background  out  12  current background colour
xpos, ypos  out  10 each  sprite centre
lives  out  3  remaining lives
state  out  2  game state (encoding from package)

Behaviour:
- Reset (async, rst high): xpos=X_START, ypos=Y_START, lives=LIVES, state=RUN, background=12'hFFF, hit/goal flags=0, frame counters=0. rgb is combinational.
- frame_end strobe: one clk when hCount==0 && vCount==0. All position/state updates occur only on frame_end. They are visible from the next frame (1 frame latency).
- sprite_fill = vCount in [ypos-HALF, ypos+HALF] and hCount in [xpos-HALF, xpos+HALF]. Compute at 11 bits; no underflow wrap.
- Scan flags: hit_flag is set when bright && sprite_fill && wall_fill. goal_flag is set when bright && sprite_fill && goal_fill. Both are sticky within a frame, sampled and cleared on frame_end.
- rgb priority:
  - ~bright -> 0
  - sprite_fill -> SPRITE_COLOR; in HIT, sprite is blanked on frames where hit_cnt[3]==1 (flash)
  - wall_fill -> 0
  - else background
- State transitions on frame_end:
  - RUN: if hit_flag -> lives-1, position=START, hit_cnt=0. If lives was 1 -> OVER (lives=0), else -> HIT. Else if goal_flag -> WIN. Else, if move_cnt==MOVE_DIV-1, apply move and clear move_cnt; otherwise increment move_cnt.
  - HIT: no movement; hit_cnt+1; at hit_cnt==HIT_FRAMES-1 -> RUN, move_cnt=0.
  - WIN, OVER: terminal; frozen until rst.
  - Collision beats goal when both are set in the same frame.
- Move rules:
  - right: xpos=min(xpos+STEP, X_MAX); left: xpos=max(xpos-STEP, X_MIN); same pattern for down/up on ypos.
  - left&&right: no x change; up&&down: no y change. Diagonal moves are allowed.
- Background:
  - In RUN/HIT, background tracks the last direction pressed, priority right (FF0) > left (0FF) > down (0F0) > up (00F), updated on frame_end. It holds when no button is pressed.
  - WIN forces 0F0; OVER forces F00.
- rst mid-frame: flags are cleared. Any partial-frame hit is discarded.

Optional Feature:
WRAP_EN:
- Defined: moving past X_MAX wraps x to X_MIN (and vice versa). The same applies to y between Y_MIN and Y_MAX. The wrap is exact; leftover step is discarded.
- Undefined: saturating clamp as specified in Behaviour.

Decomposition:
- Package maze_pkg holds: state encoding (RUN=0, HIT=1, WIN=2, OVER=3), colour constants (BLACK, WHITE, RED, GREEN, YELLOW, CYAN, BLUE), coordinate width (10).
- Sub-module scan_flag_latch: generates frame_end, holds the sticky hit/goal flags, and presents their sampled values on the frame_end cycle.

Test Plan:
1. Reset, then hold right for 10 frames (STEP=1, MOVE_DIV=1) -> xpos 450->460, ypos 250, background FF0 after first frame_end.
2. Hold left from xpos=152 for 5 frames -> xpos saturates at 150. With WRAP_EN, the 3rd move produces 780.
3. Assert wall_fill over the sprite area for one frame -> next frame_end: state=HIT, lives 3->2, pos=(450,250). Buttons are ignored for 60 frames, then state=RUN.
4. Force a collision three times -> lives reaches 0, state=OVER, background F00. Buttons and further walls have no effect until rst.
5. goal_fill and wall_fill both over the sprite in the same frame -> collision wins (HIT, lives-1). goal_fill alone -> WIN, background 0F0.
6. left+right held with MOVE_DIV=4 for 8 frames -> xpos unchanged; up alone for 8 frames -> ypos -2. Assert rst mid-frame -> all outputs return to reset values immediately.
